// File: rtl/bram_arb_pkg.sv
`default_nettype none
//============================================================================
// Module : bram_arb_pkg
// Brief  : Shared types and constants for the TDP36K port arbiter.
// Rev    : 1.0 - initial release
//============================================================================
package bram_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Port widths supported by the BRAM2x18 technology maps
  localparam int c_mode_w1  = 1;
  localparam int c_mode_w2  = 2;
  localparam int c_mode_w4  = 4;
  localparam int c_mode_w9  = 9;
  localparam int c_mode_w18 = 18;
  localparam int c_mode_w36 = 36;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick starting after last_grant.
// Rev    : 1.0 - initial release
//============================================================================
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Walk candidates from farthest to nearest so the nearest requester wins
  always_comb begin
    int c;
    c           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      c = int'(last_grant) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[IDX_W'(c)]) begin
        grant              = '0;
        grant[IDX_W'(c)]   = 1'b1;
        grant_idx          = IDX_W'(c);
        grant_valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
//============================================================================
// Module : bram_port_arbiter
// Brief  : Round-robin sharing of one TDP36K port with a zero-fill sequencer.
// Rev    : 1.0 - initial release
//============================================================================
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18,
  parameter int BE_W    = 2,
  parameter int DEPTH   = 1024
) (
  input  logic                      CLK_i,
  input  logic                      RST_N_i,
  input  logic [NUM_REQ-1:0]        REQ_VALID_i,
  output logic [NUM_REQ-1:0]        REQ_READY_o,
  input  logic [NUM_REQ-1:0]        REQ_WE_i,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR_i,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA_i,
  input  logic [NUM_REQ*BE_W-1:0]   REQ_BE_i,
  output logic [NUM_REQ-1:0]        RSP_VALID_o,
  output logic [DATA_W-1:0]         RSP_RDATA_o,
  input  logic                      CLR_i,
  output logic                      CLR_BUSY_o,
  output logic                      CLR_DONE_o,
  output logic                      RAM_REN_o,
  output logic                      RAM_WEN_o,
  output logic [BE_W-1:0]           RAM_BE_o,
  output logic [ADDR_W-1:0]         RAM_ADDR_o,
  output logic [DATA_W-1:0]         RAM_WDATA_o,
  input  logic [DATA_W-1:0]         RAM_RDATA_i
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = ADDR_W + 1;

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_last_grant;
  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_grant_valid;
  logic                 w_accept;
  logic                 w_win_we;

  logic                 r_rsp_v1;
  logic [IDX_W-1:0]     r_rsp_idx1;
  logic [NUM_REQ-1:0]   r_rsp_vec;

  logic                 r_ren;
  logic                 r_wen;
  logic [BE_W-1:0]      r_be;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [CNT_W-1:0]     r_clr_cnt;
  logic                 r_busy;
  logic                 r_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (REQ_VALID_i),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  // A pending clear pre-empts every requester in the same cycle
  assign w_accept    = RST_N_i && (r_state == ARB) && !CLR_i && w_grant_valid;
  assign w_win_we    = REQ_WE_i[w_grant_idx];
  assign REQ_READY_o = w_accept ? w_grant : '0;

  assign RSP_VALID_o = r_rsp_vec;
  assign RSP_RDATA_o = RAM_RDATA_i;
  assign CLR_BUSY_o  = r_busy;
  assign CLR_DONE_o  = r_done;
  assign RAM_REN_o   = r_ren;
  assign RAM_WEN_o   = r_wen;
  assign RAM_BE_o    = r_be;
  assign RAM_ADDR_o  = r_addr;
  assign RAM_WDATA_o = r_wdata;

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      r_state      <= ARB;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_rsp_v1     <= 1'b0;
      r_rsp_idx1   <= '0;
      r_rsp_vec    <= '0;
      r_ren        <= 1'b0;
      r_wen        <= 1'b0;
      r_be         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_clr_cnt    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_done     <= 1'b0;
      r_rsp_v1   <= w_accept && !w_win_we;
      r_rsp_idx1 <= w_grant_idx;
      r_rsp_vec  <= '0;
      if (r_rsp_v1) r_rsp_vec[r_rsp_idx1] <= 1'b1;
      if (r_done) r_busy <= 1'b0;

      case (r_state)
        ARB: begin
          if (CLR_i) begin
            // Address 0 is issued from ARB so write k lands k+1 cycles after CLR_i
            r_wen     <= 1'b1;
            r_be      <= '1;
            r_wdata   <= '0;
            r_addr    <= '0;
            r_clr_cnt <= CNT_W'(1);
            r_busy    <= 1'b1;
            if (DEPTH == 1) r_done  <= 1'b1;
            else            r_state <= CLEAR;
          end else if (w_accept) begin
            r_ren        <= !w_win_we;
            r_wen        <= w_win_we;
            r_addr       <= REQ_ADDR_i[int'(w_grant_idx)*ADDR_W +: ADDR_W];
            r_wdata      <= REQ_WDATA_i[int'(w_grant_idx)*DATA_W +: DATA_W];
            r_be         <= REQ_BE_i[int'(w_grant_idx)*BE_W +: BE_W];
            r_last_grant <= w_grant_idx;
          end
        end
        CLEAR: begin
          r_wen     <= 1'b1;
          r_be      <= '1;
          r_wdata   <= '0;
          r_addr    <= r_clr_cnt[ADDR_W-1:0];
          r_clr_cnt <= r_clr_cnt + CNT_W'(1);
          if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
            r_done  <= 1'b1;
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire
